// File: rtl/condlogic_it_pkg.sv
// Shared types for the conditional-execution unit: condition codes, flag layout, IT FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } itstate_e;

  // Bit positions inside FlagW
  localparam int FLAGGRP_NZ = 1;
  localparam int FLAGGRP_CV = 0;

  // Condition of the current IT slot: mask bit set selects the base condition,
  // clear selects its inverse (flip of the LSB inverts every ARM condition pair).
  function automatic logic [3:0] it_slot_cond(input logic [3:0] base, input logic sel);
    return sel ? base : (base ^ 4'b0001);
  endfunction

endpackage

// File: rtl/condlogic_it_if.sv
// Decoder/ALU-facing bundle of the conditional-execution unit.
// Latency: n/a (wiring only).
// Backpressure: n/a; 'en' is the stall qualifier carried in the bundle.
// Ports: master drives decoder requests, ALU flags and IT controls; slave returns gated enables,
// CondEx, Flags, InIT and Undef.
interface condlogic_it_if #(
  parameter int ITDEPTH = 4
);
  logic               en;
  logic               flush;
  logic [3:0]         Cond;
  logic [3:0]         ALUFlags;
  logic [1:0]         FlagW;
  logic               PCS;
  logic               RegW;
  logic               MemW;
  logic               NoWrite;
  logic               ITStart;
  logic [3:0]         ITCond;
  logic [2:0]         ITLen;
  logic [ITDEPTH-1:0] ITMask;

  logic               PCSrc;
  logic               RegWrite;
  logic               MemWrite;
  logic               CondEx;
  logic [3:0]         Flags;
  logic               InIT;
  logic               Undef;

  modport master (
    output en, flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
           ITStart, ITCond, ITLen, ITMask,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, InIT, Undef
  );

  modport slave (
    input  en, flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
           ITStart, ITCond, ITLen, ITMask,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, InIT, Undef
  );
endinterface

// File: rtl/condlogic_it_cond_eval.sv
// Evaluates an ARM condition code against the NZCV flags.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_cond (condition code), i_flags (NZCV), o_condex (condition passed), o_undef (NV code).
module cond_eval
  import cond_pkg::*;
(
  input  cond_e  i_cond,
  input  flags_t i_flags,
  output logic   o_condex,
  output logic   o_undef
);
  always_comb begin
    o_condex = 1'b0;
    o_undef  = 1'b0;
    case (i_cond)
      EQ: o_condex = i_flags.z;
      NE: o_condex = ~i_flags.z;
      CS: o_condex = i_flags.c;
      CC: o_condex = ~i_flags.c;
      MI: o_condex = i_flags.n;
      PL: o_condex = ~i_flags.n;
      VS: o_condex = i_flags.v;
      VC: o_condex = ~i_flags.v;
      HI: o_condex = i_flags.c & ~i_flags.z;
      LS: o_condex = ~i_flags.c | i_flags.z;
      GE: o_condex = (i_flags.n == i_flags.v);
      LT: o_condex = (i_flags.n != i_flags.v);
      GT: o_condex = ~i_flags.z & (i_flags.n == i_flags.v);
      LE: o_condex = i_flags.z | (i_flags.n != i_flags.v);
      AL: o_condex = 1'b1;
      // NV (1111) never executes and is reported as undefined
      default: o_undef = 1'b1;
    endcase
  end
endmodule

// File: rtl/condlogic_it_flopenr.sv
// Enabled register with asynchronous active-high reset.
// Latency: 1 cycle from d to q when i_en is high.
// Backpressure: i_en low holds the stored value.
// Ports: clk, reset, i_en (load strobe), i_d (next value), o_q (stored value).
module flopenr #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/condlogic_it.sv
// Execute-stage conditional unit: NZCV register, condition gating, If-Then slot sequencer.
// Latency: gated enables/CondEx/Undef combinational; Flags and InIT registered (1 cycle).
// Backpressure: en=0 stalls and holds all state; flush squashes the slot and ends any IT block.
// Ports: clk, reset (async, active high), bus (slave side of condlogic_it_if).
module condlogic_it
  import cond_pkg::*;
#(
  parameter int ITDEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  condlogic_it_if.slave  bus
);
  itstate_e           r_state, w_state_nxt;
  logic [2:0]         r_slot_left, w_slot_left_nxt;
  logic [ITDEPTH-1:0] r_mask_q, w_mask_nxt;
  logic [3:0]         r_base_q, w_base_nxt;

  logic [1:0]         w_nz_q, w_cv_q;
  flags_t             w_flags;
  logic               w_in_it;
  logic [3:0]         w_eff_cond;
  logic               w_condex_raw, w_cond_undef;
  logic               w_valid, w_len_ok, w_it_load, w_it_illegal, w_exec;
  logic               w_pcsrc;
  logic [1:0]         w_flag_we;
  logic [2:0]         w_slot_dec;

  assign w_in_it    = (r_state == ACTIVE);
  assign w_eff_cond = w_in_it ? it_slot_cond(r_base_q, r_mask_q[0]) : bus.Cond;
  assign w_flags    = {w_nz_q, w_cv_q};

  cond_eval u_cond_eval (
    .i_cond   (cond_e'(w_eff_cond)),
    .i_flags  (w_flags),
    .o_condex (w_condex_raw),
    .o_undef  (w_cond_undef)
  );

  // A real instruction occupies Execute; reset forces every output low.
  assign w_valid      = bus.en & ~bus.flush & ~reset;
  assign w_len_ok     = (bus.ITLen != 3'd0) && (bus.ITLen <= 3'(ITDEPTH));
  assign w_it_load    = w_valid & bus.ITStart & ~w_in_it & w_len_ok;
  // Nested IT or an out-of-range length
  assign w_it_illegal = w_valid & bus.ITStart & (w_in_it | ~w_len_ok);
  // The IT instruction itself never writes anything
  assign w_exec       = w_valid & ~bus.ITStart;

  assign w_pcsrc      = w_exec & bus.PCS & w_condex_raw;
  assign bus.PCSrc    = w_pcsrc;
  assign bus.MemWrite = w_exec & bus.MemW & w_condex_raw;
  assign bus.RegWrite = w_exec & bus.RegW & w_condex_raw & ~bus.NoWrite;
  assign bus.CondEx   = ~reset & w_condex_raw;
  assign bus.Undef    = (w_valid & w_cond_undef) | w_it_illegal;
  assign bus.Flags    = w_flags;
  assign bus.InIT     = w_in_it;

  // NoWrite only suppresses the register write; CMP/TST still update flags.
  assign w_flag_we[FLAGGRP_NZ] = w_exec & bus.FlagW[FLAGGRP_NZ] & w_condex_raw;
  assign w_flag_we[FLAGGRP_CV] = w_exec & bus.FlagW[FLAGGRP_CV] & w_condex_raw;

  flopenr #(.WIDTH(2)) u_flag_nz (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_flag_we[FLAGGRP_NZ]),
    .i_d   (bus.ALUFlags[3:2]),
    .o_q   (w_nz_q)
  );

  flopenr #(.WIDTH(2)) u_flag_cv (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_flag_we[FLAGGRP_CV]),
    .i_d   (bus.ALUFlags[1:0]),
    .o_q   (w_cv_q)
  );

  assign w_slot_dec = r_slot_left - 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_slot_left <= 3'd0;
      r_mask_q    <= '0;
      r_base_q    <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_slot_left <= w_slot_left_nxt;
      r_mask_q    <= w_mask_nxt;
      r_base_q    <= w_base_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_slot_left_nxt = r_slot_left;
    w_mask_nxt      = r_mask_q;
    w_base_nxt      = r_base_q;
    case (r_state)
      IDLE: begin
        if (w_it_load) begin
          w_state_nxt     = ACTIVE;
          w_slot_left_nxt = bus.ITLen;
          w_mask_nxt      = bus.ITMask;
          w_base_nxt      = bus.ITCond;
        end
      end
      ACTIVE: begin
        // Flush ends the block even during a stall; otherwise en=0 holds the slot.
        if (bus.flush || (bus.en && (bus.ITStart || w_pcsrc || w_slot_dec == 3'd0))) begin
          w_state_nxt     = IDLE;
          w_slot_left_nxt = 3'd0;
          w_mask_nxt      = '0;
          w_base_nxt      = 4'd0;
        end else if (bus.en) begin
          w_slot_left_nxt = w_slot_dec;
          w_mask_nxt      = r_mask_q >> 1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_condlogic_it.sv
module tb_condlogic_it;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  condlogic_it_if #(.ITDEPTH(4)) bus ();
  condlogic_it #(.ITDEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: flags plus a queue of the conditions still pending in the IT block.
  logic [3:0] m_flags;
  logic [3:0] m_itq[$];
  logic e_pcsrc, e_regw, e_memw, e_condex, e_undef, e_exec, e_init;

  function automatic logic m_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;        4'h1: return !z;
      4'h2: return cf;       4'h3: return !cf;
      4'h4: return n;        4'h5: return !n;
      4'h6: return v;        4'h7: return !v;
      4'h8: return cf && !z; 4'h9: return !cf || z;
      4'hA: return n == v;   4'hB: return n != v;
      4'hC: return !z && n == v;
      4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_eval();
    logic [3:0] eff;
    logic bad_len;
    e_init  = (m_itq.size() != 0);
    eff     = e_init ? m_itq[0] : bus.Cond;
    bad_len = (bus.ITLen == 0) || (bus.ITLen > 4);
    e_condex = m_pass(eff, m_flags);
    e_exec   = bus.en && !bus.flush && !bus.ITStart;
    e_pcsrc  = e_exec && bus.PCS && e_condex;
    e_memw   = e_exec && bus.MemW && e_condex;
    e_regw   = e_exec && bus.RegW && !bus.NoWrite && e_condex;
    e_undef  = bus.en && !bus.flush && (eff == 4'hF || (bus.ITStart && (e_init || bad_len)));
  endtask

  task automatic model_commit();
    if (bus.flush) m_itq.delete();
    else if (bus.en) begin
      if (e_exec && e_condex && bus.FlagW[1]) m_flags[3:2] = bus.ALUFlags[3:2];
      if (e_exec && e_condex && bus.FlagW[0]) m_flags[1:0] = bus.ALUFlags[1:0];
      if (bus.ITStart) begin
        if (e_init || bus.ITLen == 0 || bus.ITLen > 4) m_itq.delete();
        else for (int i = 0; i < int'(bus.ITLen); i++)
          m_itq.push_back(bus.ITMask[i] ? bus.ITCond : (bus.ITCond ^ 4'h1));
      end else if (e_init) begin
        if (e_pcsrc) m_itq.delete();
        else void'(m_itq.pop_front());
      end
    end
  endtask

  task automatic clear_inputs();
    bus.en = 0; bus.flush = 0; bus.Cond = 4'hE; bus.ALUFlags = 0; bus.FlagW = 0;
    bus.PCS = 0; bus.RegW = 0; bus.MemW = 0; bus.NoWrite = 0;
    bus.ITStart = 0; bus.ITCond = 0; bus.ITLen = 0; bus.ITMask = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_reset();
    cycle(); reset = 1;
    cycle(); reset = 0;
  endtask

  // Sets Z=1 (flags 0100) via an AL flag-setting instruction.
  task automatic set_z();
    cycle(); bus.en = 1; bus.Cond = 4'hE; bus.ALUFlags = 4'b0100; bus.FlagW = 2'b11;
  endtask

  task automatic start_it(input logic [3:0] c, input logic [2:0] len, input logic [3:0] mask);
    cycle(); bus.en = 1; bus.ITStart = 1; bus.ITCond = c; bus.ITLen = len; bus.ITMask = mask;
  endtask

  task automatic test_reset();
    clear_inputs(); reset = 1;
    bus.en = 1; bus.Cond = 4'hE; bus.RegW = 1; bus.MemW = 1; bus.PCS = 1;
    bus.FlagW = 2'b11; bus.ALUFlags = 4'hF;
    @(negedge clk); #1;
    checks++;
    if ({bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.CondEx, bus.Undef} !== 5'b0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=00000",
                           {bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.CondEx, bus.Undef});
    end
    checks++;
    if (bus.Flags !== 4'b0 || bus.InIT !== 1'b0) begin
      failures++; $display("FAIL reset_state Flags=%b InIT=%b exp 0000/0", bus.Flags, bus.InIT);
    end
    cycle(); reset = 0;
  endtask

  task automatic test_flags_basic();
    cycle(); bus.en = 1; bus.Cond = 4'h0; bus.RegW = 1; #1;
    checks++;
    if (bus.RegWrite !== 1'b0) begin
      failures++; $display("FAIL eq_z0_regwrite got=%b exp=0", bus.RegWrite);
    end
    cycle(); bus.en = 1; bus.Cond = 4'hE; bus.RegW = 1; bus.ALUFlags = 4'b0100; bus.FlagW = 2'b11;
    cycle(); bus.en = 1; bus.Cond = 4'h0; bus.RegW = 1; #1;
    checks++;
    if (bus.Flags !== 4'b0100) begin
      failures++; $display("FAIL subs_flags got=%b exp=0100", bus.Flags);
    end
    checks++;
    if (bus.RegWrite !== 1'b1) begin
      failures++; $display("FAIL eq_z1_regwrite got=%b exp=1", bus.RegWrite);
    end
  endtask

  task automatic test_group_isolation();
    do_reset();
    cycle(); bus.en = 1; bus.ALUFlags = 4'b1111; bus.FlagW = 2'b10;
    cycle(); bus.en = 1; bus.ALUFlags = 4'b1111; bus.FlagW = 2'b01; #1;
    checks++;
    if (bus.Flags !== 4'b1100) begin
      failures++; $display("FAIL group_nz got=%b exp=1100", bus.Flags);
    end
    cycle(); #1;
    checks++;
    if (bus.Flags !== 4'b1111) begin
      failures++; $display("FAIL group_cv got=%b exp=1111", bus.Flags);
    end
  endtask

  task automatic test_it_block();
    logic [2:0] exp_rw;
    exp_rw = 3'b101;  // slot0 EQ, slot1 NE, slot2 EQ with Z=1
    do_reset(); set_z();
    start_it(4'h0, 3'd3, 4'b0101); bus.RegW = 1; #1;
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.InIT !== 1'b0) begin
      failures++; $display("FAIL it_instr RegWrite=%b InIT=%b exp 0/0", bus.RegWrite, bus.InIT);
    end
    for (int s = 0; s < 3; s++) begin
      cycle(); bus.en = 1; bus.RegW = 1; bus.Cond = 4'hE; #1;
      checks++;
      if (bus.InIT !== 1'b1 || bus.RegWrite !== exp_rw[s]) begin
        failures++; $display("FAIL it_slot%0d InIT=%b RegWrite=%b exp 1/%b",
                             s, bus.InIT, bus.RegWrite, exp_rw[s]);
      end
    end
    cycle(); bus.en = 1; bus.RegW = 1; bus.Cond = 4'h1; #1;
    checks++;
    if (bus.InIT !== 1'b0 || bus.RegWrite !== 1'b0) begin
      failures++; $display("FAIL it_end InIT=%b RegWrite=%b exp 0/0", bus.InIT, bus.RegWrite);
    end
  endtask

  task automatic test_stall_mid_it();
    do_reset(); set_z();
    start_it(4'h0, 3'd3, 4'b0101);
    cycle(); bus.en = 1; bus.MemW = 1; #1;
    checks++;
    if (bus.MemWrite !== 1'b1) begin
      failures++; $display("FAIL stall_slot0 MemWrite=%b exp=1", bus.MemWrite);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(); bus.en = 0; bus.MemW = 1; bus.RegW = 1; bus.Cond = 4'hE; #1;
      checks++;
      if (bus.MemWrite !== 1'b0 || bus.RegWrite !== 1'b0 || bus.InIT !== 1'b1) begin
        failures++; $display("FAIL stall_hold%0d MemWrite=%b RegWrite=%b InIT=%b exp 0/0/1",
                             k, bus.MemWrite, bus.RegWrite, bus.InIT);
      end
    end
    cycle(); bus.en = 1; bus.MemW = 1; #1;
    checks++;
    if (bus.MemWrite !== 1'b0 || bus.InIT !== 1'b1) begin
      failures++; $display("FAIL stall_slot1 MemWrite=%b InIT=%b exp 0/1", bus.MemWrite, bus.InIT);
    end
    cycle(); bus.en = 1; bus.MemW = 1; #1;
    checks++;
    if (bus.MemWrite !== 1'b1 || bus.InIT !== 1'b1) begin
      failures++; $display("FAIL stall_slot2 MemWrite=%b InIT=%b exp 1/1", bus.MemWrite, bus.InIT);
    end
    cycle(); #1;
    checks++;
    if (bus.InIT !== 1'b0) begin
      failures++; $display("FAIL stall_end InIT=%b exp=0", bus.InIT);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    cycle(); bus.en = 1; bus.Cond = 4'hF; bus.MemW = 1; #1;
    checks++;
    if (bus.Undef !== 1'b1 || bus.MemWrite !== 1'b0) begin
      failures++; $display("FAIL cond_nv Undef=%b MemWrite=%b exp 1/0", bus.Undef, bus.MemWrite);
    end
    start_it(4'h0, 3'd0, 4'b1111); #1;
    checks++;
    if (bus.Undef !== 1'b1) begin
      failures++; $display("FAIL itlen0_undef got=%b exp=1", bus.Undef);
    end
    start_it(4'h0, 3'd5, 4'b1111); #1;
    checks++;
    if (bus.Undef !== 1'b1 || bus.InIT !== 1'b0) begin
      failures++; $display("FAIL itlen5 Undef=%b InIT=%b exp 1/0", bus.Undef, bus.InIT);
    end
    cycle(); #1;
    checks++;
    if (bus.InIT !== 1'b0) begin
      failures++; $display("FAIL itlen_bad_idle InIT=%b exp=0", bus.InIT);
    end
    start_it(4'hE, 3'd2, 4'b0010);
    cycle(); bus.en = 1; bus.RegW = 1; #1;
    checks++;
    if (bus.Undef !== 1'b1 || bus.CondEx !== 1'b0 || bus.RegWrite !== 1'b0) begin
      failures++; $display("FAIL it_al_inverted Undef=%b CondEx=%b RegWrite=%b exp 1/0/0",
                           bus.Undef, bus.CondEx, bus.RegWrite);
    end
    cycle(); bus.en = 1; bus.RegW = 1; #1;
    checks++;
    if (bus.Undef !== 1'b0 || bus.CondEx !== 1'b1 || bus.RegWrite !== 1'b1) begin
      failures++; $display("FAIL it_al_slot1 Undef=%b CondEx=%b RegWrite=%b exp 0/1/1",
                           bus.Undef, bus.CondEx, bus.RegWrite);
    end
  endtask

  task automatic test_flush_and_async_reset();
    do_reset(); set_z();
    start_it(4'h0, 3'd4, 4'b1111);
    cycle(); bus.en = 1; bus.RegW = 1; #1;
    checks++;
    if (bus.RegWrite !== 1'b1) begin
      failures++; $display("FAIL flush_slot0 RegWrite=%b exp=1", bus.RegWrite);
    end
    cycle(); bus.en = 1; bus.RegW = 1; bus.flush = 1; #1;
    checks++;
    if (bus.RegWrite !== 1'b0) begin
      failures++; $display("FAIL flush_slot1 RegWrite=%b exp=0", bus.RegWrite);
    end
    cycle(); bus.en = 1; bus.RegW = 1; bus.Cond = 4'h1; #1;
    checks++;
    if (bus.InIT !== 1'b0 || bus.CondEx !== 1'b0 || bus.RegWrite !== 1'b0) begin
      failures++; $display("FAIL after_flush InIT=%b CondEx=%b RegWrite=%b exp 0/0/0",
                           bus.InIT, bus.CondEx, bus.RegWrite);
    end
    start_it(4'h0, 3'd4, 4'b1111);
    cycle(); bus.en = 1; #1;
    checks++;
    if (bus.InIT !== 1'b1 || bus.Flags !== 4'b0100) begin
      failures++; $display("FAIL pre_async InIT=%b Flags=%b exp 1/0100", bus.InIT, bus.Flags);
    end
    bus.en = 0; #1; reset = 1; #1;
    checks++;
    if (bus.InIT !== 1'b0 || bus.Flags !== 4'b0000) begin
      failures++; $display("FAIL async_reset InIT=%b Flags=%b exp 0/0000", bus.InIT, bus.Flags);
    end
    #1; reset = 0;
  endtask

  task automatic test_random();
    do_reset();
    m_flags = 4'b0; m_itq.delete();
    for (int t = 0; t < 600; t++) begin
      cycle();
      bus.en       = ($urandom_range(0, 9) != 0);
      bus.flush    = ($urandom_range(0, 24) == 0);
      bus.Cond     = 4'($urandom_range(0, 15));
      bus.ALUFlags = 4'($urandom_range(0, 15));
      bus.FlagW    = 2'($urandom_range(0, 3));
      bus.PCS      = ($urandom_range(0, 7) == 0);
      bus.RegW     = 1'($urandom_range(0, 1));
      bus.MemW     = 1'($urandom_range(0, 1));
      bus.NoWrite  = ($urandom_range(0, 3) == 0);
      bus.ITStart  = ($urandom_range(0, 6) == 0);
      bus.ITCond   = 4'($urandom_range(0, 15));
      bus.ITLen    = 3'($urandom_range(0, 5));
      bus.ITMask   = 4'($urandom_range(0, 15));
      #1;
      model_eval();
      checks++;
      if ({bus.PCSrc, bus.RegWrite, bus.MemWrite} !== {e_pcsrc, e_regw, e_memw}) begin
        failures++; $display("FAIL rand_enables t=%0d got=%b exp=%b", t,
                             {bus.PCSrc, bus.RegWrite, bus.MemWrite}, {e_pcsrc, e_regw, e_memw});
      end
      checks++;
      if (bus.CondEx !== e_condex || bus.Undef !== e_undef) begin
        failures++; $display("FAIL rand_cond t=%0d CondEx=%b Undef=%b exp %b/%b", t,
                             bus.CondEx, bus.Undef, e_condex, e_undef);
      end
      checks++;
      if (bus.Flags !== m_flags || bus.InIT !== e_init) begin
        failures++; $display("FAIL rand_state t=%0d Flags=%b InIT=%b exp %b/%b", t,
                             bus.Flags, bus.InIT, m_flags, e_init);
      end
      model_commit();
    end
  endtask

  initial begin
    test_reset();
    test_flags_basic();
    test_group_isolation();
    test_it_block();
    test_stall_mid_it();
    test_illegal();
    test_flush_and_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
